// File: rtl/datapath_controller.sv
// Instruction decoder and Moore FSM that sequences the 16-bit register/ALU datapath.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instructions trap into HALT and raise err).
module datapath_controller #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s,
  input  logic [15:0]  in,
  output logic         w,
  output logic         err,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic [3:0]   vsel,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         write,
  output logic         asel,
  output logic         bsel,
  output logic [1:0]   shift,
  output logic [1:0]   ALUop,
  output logic [W-1:0] sximm8,
  output logic [W-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // IR field views
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  assign sximm8 = {{(W-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{(W-5){ir_q[4]}}, ir_q[4:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // The only IR write port: a start accepted while idle.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && s) ir_d = in;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    w        = 1'b0;
    err      = 1'b0;
    readnum  = rn;
    writenum = rd;
    shift    = sh;
    ALUop    = op;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        w        = 1'b1;
        readnum  = 3'd0;
        writenum = 3'd0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        if (s) state_d = S_DECODE;
      end

      S_DECODE: begin
        if (is_mov_imm)                          state_d = S_WRITE_IMM;
        else if (is_alu && !is_mvn)              state_d = S_GET_A;
        else if (is_mov_reg || is_mvn)           state_d = S_GET_B;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WAIT;
`endif
        end
      end

      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end

      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end

      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (is_mov_reg) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end
        // CMP only updates status; nothing is written back.
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end

      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end

`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        err     = 1'b1;
        state_d = S_HALT;
      end
`endif

      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed self-checking bench for datapath_controller: per-cycle strobe traces of each instruction class.
// Build with +define+ILLEGAL_TRAP_EN to exercise the trapping variant of the illegal-opcode test.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w, err, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int passes = 0;

  datapath_controller #(.W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(instr),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  // Strobe vector {w,err,loada,loadb,loadc,loads,write,asel,bsel}
  localparam logic [8:0] ST_IDLE = 9'b100000000;
  localparam logic [8:0] ST_BUSY = 9'b000000000;
  localparam logic [8:0] ST_HALT = 9'b010000000;
  localparam logic [8:0] ST_LA   = 9'b001000000;
  localparam logic [8:0] ST_LB   = 9'b000100000;
  localparam logic [8:0] ST_LC   = 9'b000010000;
  localparam logic [8:0] ST_LS   = 9'b000001000;
  localparam logic [8:0] ST_WR   = 9'b000000100;
  localparam logic [8:0] ST_MOVX = 9'b000010010;

  function automatic logic [8:0] strb();
    return {w, err, loada, loadb, loadc, loads, write, asel, bsel};
  endfunction

  // Presents an instruction with s high across one rising edge; returns just after that edge.
  task automatic start_instr(input logic [15:0] i);
    @(negedge clk);
    instr = i;
    s     = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; instr = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL reset_strobes got %b exp %b", strb(), ST_IDLE); else passes++;
    checks++; if (vsel !== 4'b0001) $display("FAIL reset_vsel got %b exp 0001", vsel); else passes++;
    checks++; if ({sximm8, sximm5} !== 32'h0) $display("FAIL reset_imm got %h/%h exp 0/0", sximm8, sximm5); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_mov_imm();
    start_instr(16'hD007);
    @(negedge clk);
    checks++; if (strb() !== ST_BUSY) $display("FAIL movi_decode got %b exp %b", strb(), ST_BUSY); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_WR) $display("FAIL movi_write got %b exp %b", strb(), ST_WR); else passes++;
    checks++; if ({writenum, vsel} !== {3'd0, 4'b0100}) $display("FAIL movi_wsel got %0d/%b exp 0/0100", writenum, vsel); else passes++;
    checks++; if (sximm8 !== 16'h0007) $display("FAIL movi_sximm8 got %h exp 0007", sximm8); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL movi_done got %b exp %b", strb(), ST_IDLE); else passes++;
  endtask

  task automatic test_mov_neg();
    start_instr(16'hD1FF);
    @(negedge clk);
    checks++; if (write !== 1'b0) $display("FAIL movn_early_write got %b exp 0", write); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_WR) $display("FAIL movn_write got %b exp %b", strb(), ST_WR); else passes++;
    checks++; if (writenum !== 3'd1) $display("FAIL movn_writenum got %0d exp 1", writenum); else passes++;
    checks++; if ({sximm8, sximm5} !== 32'hFFFF_FFFF) $display("FAIL movn_sext got %h/%h exp ffff/ffff", sximm8, sximm5); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL movn_done got %b exp %b", strb(), ST_IDLE); else passes++;
  endtask

  // Three-operand ALU op: DECODE, GET_A, GET_B, EXEC, WRITE_REG, then idle on the 6th sample.
  task automatic test_alu3(input string nm, input logic [15:0] i, input logic [2:0] rn, input logic [2:0] rm,
                           input logic [1:0] sh, input logic [1:0] aop, input logic [2:0] rd);
    start_instr(i);
    @(negedge clk);
    checks++; if (strb() !== ST_BUSY) $display("FAIL %s_decode got %b exp %b", nm, strb(), ST_BUSY); else passes++;
    @(negedge clk);
    checks++; if ({strb(), readnum} !== {ST_LA, rn}) $display("FAIL %s_get_a got %b/%0d exp %b/%0d", nm, strb(), readnum, ST_LA, rn); else passes++;
    @(negedge clk);
    checks++; if ({strb(), readnum} !== {ST_LB, rm}) $display("FAIL %s_get_b got %b/%0d exp %b/%0d", nm, strb(), readnum, ST_LB, rm); else passes++;
    @(negedge clk);
    checks++; if ({strb(), shift, ALUop} !== {ST_LC, sh, aop}) $display("FAIL %s_exec got %b/%b/%b exp %b/%b/%b", nm, strb(), shift, ALUop, ST_LC, sh, aop); else passes++;
    @(negedge clk);
    checks++; if ({strb(), writenum, vsel} !== {ST_WR, rd, 4'b0001}) $display("FAIL %s_wreg got %b/%0d/%b exp %b/%0d/0001", nm, strb(), writenum, vsel, ST_WR, rd); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL %s_done got %b exp %b", nm, strb(), ST_IDLE); else passes++;
  endtask

  task automatic test_cmp();
    start_instr(16'hA900);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({strb(), readnum} !== {ST_LA, 3'd1}) $display("FAIL cmp_get_a got %b/%0d exp %b/1", strb(), readnum, ST_LA); else passes++;
    @(negedge clk);
    checks++; if ({strb(), readnum} !== {ST_LB, 3'd0}) $display("FAIL cmp_get_b got %b/%0d exp %b/0", strb(), readnum, ST_LB); else passes++;
    @(negedge clk);
    checks++; if ({strb(), ALUop} !== {ST_LS, 2'b01}) $display("FAIL cmp_exec got %b/%b exp %b/01", strb(), ALUop, ST_LS); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL cmp_done got %b exp %b", strb(), ST_IDLE); else passes++;
  endtask

  // Single-operand op: DECODE, GET_B, EXEC, WRITE_REG, idle on the 5th sample.
  task automatic test_unary(input string nm, input logic [15:0] i, input logic [2:0] rm, input logic [8:0] exec_st,
                            input logic [1:0] sh, input logic [1:0] aop, input logic [2:0] rd);
    start_instr(i);
    @(negedge clk);
    @(negedge clk);
    checks++; if ({strb(), readnum} !== {ST_LB, rm}) $display("FAIL %s_get_b got %b/%0d exp %b/%0d", nm, strb(), readnum, ST_LB, rm); else passes++;
    @(negedge clk);
    checks++; if ({strb(), shift, ALUop} !== {exec_st, sh, aop}) $display("FAIL %s_exec got %b/%b/%b exp %b/%b/%b", nm, strb(), shift, ALUop, exec_st, sh, aop); else passes++;
    @(negedge clk);
    checks++; if ({strb(), writenum} !== {ST_WR, rd}) $display("FAIL %s_wreg got %b/%0d exp %b/%0d", nm, strb(), writenum, ST_WR, rd); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL %s_done got %b exp %b", nm, strb(), ST_IDLE); else passes++;
  endtask

  task automatic test_illegal(input string nm, input logic [15:0] i);
    start_instr(i);
    @(negedge clk);
    checks++; if (strb() !== ST_BUSY) $display("FAIL %s_decode got %b exp %b", nm, strb(), ST_BUSY); else passes++;
`ifdef ILLEGAL_TRAP_EN
    repeat (4) begin
      @(negedge clk);
      s = 1'b1;
      checks++; if (strb() !== ST_HALT) $display("FAIL %s_halt got %b exp %b", nm, strb(), ST_HALT); else passes++;
    end
    s = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (strb() !== ST_IDLE) $display("FAIL %s_unhalt got %b exp %b", nm, strb(), ST_IDLE); else passes++;
    @(negedge clk);
    reset = 1'b0;
`else
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL %s_nop_done got %b exp %b", nm, strb(), ST_IDLE); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    start_instr(16'hA148);
    repeat (3) @(negedge clk);
    checks++; if (strb() !== ST_LB) $display("FAIL rstmid_get_b got %b exp %b", strb(), ST_LB); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (strb() !== ST_IDLE) $display("FAIL rstmid_async got %b exp %b", strb(), ST_IDLE); else passes++;
    checks++; if (sximm8 !== 16'h0000) $display("FAIL rstmid_ir got %h exp 0000", sximm8); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL rstmid_hold got %b exp %b", strb(), ST_IDLE); else passes++;
    reset = 1'b0;
    start_instr(16'hD405);
    repeat (2) @(negedge clk);
    checks++; if ({strb(), writenum, sximm8} !== {ST_WR, 3'd4, 16'h0005}) $display("FAIL rstmid_resume got %b/%0d/%h exp %b/4/0005", strb(), writenum, sximm8, ST_WR); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL rstmid_resume_done got %b exp %b", strb(), ST_IDLE); else passes++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr = 16'hD205;
    s     = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({strb(), writenum} !== {ST_WR, 3'd2}) $display("FAIL b2b_first_write got %b/%0d exp %b/2", strb(), writenum, ST_WR); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL b2b_idle got %b exp %b", strb(), ST_IDLE); else passes++;
    instr = 16'hD3F0;
    @(negedge clk);
    s = 1'b0;
    checks++; if ({strb(), sximm8} !== {ST_BUSY, 16'hFFF0}) $display("FAIL b2b_second_decode got %b/%h exp %b/fff0", strb(), sximm8, ST_BUSY); else passes++;
    @(negedge clk);
    checks++; if ({strb(), writenum} !== {ST_WR, 3'd3}) $display("FAIL b2b_second_write got %b/%0d exp %b/3", strb(), writenum, ST_WR); else passes++;
    @(negedge clk);
    checks++; if (strb() !== ST_IDLE) $display("FAIL b2b_done got %b exp %b", strb(), ST_IDLE); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mov_imm();
    test_mov_neg();
    test_alu3("add", 16'hA148, 3'd1, 3'd0, 2'b01, 2'b00, 3'd2);
    test_alu3("and", 16'hB396, 3'd3, 3'd6, 2'b10, 2'b10, 3'd4);
    test_cmp();
    test_unary("movr", 16'hC07D, 3'd5, ST_MOVX, 2'b11, 2'b00, 3'd3);
    test_unary("mvn",  16'hB8E2, 3'd2, ST_LC,   2'b00, 2'b11, 3'd7);
    test_illegal("ill_e000", 16'hE000);
    test_illegal("ill_c800", 16'hC800);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
